// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and widths for the register-file write arbiter.
// Holds the controller state encoding and the RF address/data widths.
package rf_write_arbiter_pkg;

  localparam int unsigned RF_AW = 32'd5;
  localparam int unsigned RF_DW = 32'd32;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant with a one-bit priority pointer.
// The pointer only moves on a grant and then favours the other requester.
module rr_arb2 #(
  parameter int unsigned FIRST_PRIO = 32'd0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  localparam logic PRIO_RST = (FIRST_PRIO == 32'd0) ? 1'b0 : 1'b1;

  logic       prio_r;
  logic       prio_nxt_s;
  logic [1:0] gnt_s;

  // Grant selection: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    gnt_s = 2'b00;
    if (!en_i) begin
      gnt_s = 2'b00;
    end else begin
      case (req_i)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = prio_r ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Pointer next value: hand priority to the requester not just served.
  always_comb begin
    prio_nxt_s = prio_r;
    if (gnt_s[0]) begin
      prio_nxt_s = 1'b1;
    end else if (gnt_s[1]) begin
      prio_nxt_s = 1'b0;
    end else begin
      prio_nxt_s = prio_r;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_r <= PRIO_RST;
    end else begin
      prio_r <= prio_nxt_s;
    end
  end

  assign gnt_o = gnt_s;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two register-file write ports onto one registered write port,
// optionally zeroing x1..x31 after reset before any request is served.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned FIRST_PRIO     = 32'd0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  input  logic [RF_AW-1:0] req0_addr_i,
  input  logic [RF_DW-1:0] req0_data_i,
  input  logic             req1_valid_i,
  input  logic [RF_AW-1:0] req1_addr_i,
  input  logic [RF_DW-1:0] req1_data_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  output logic             rf_we_o,
  output logic [RF_AW-1:0] rf_waddr_o,
  output logic [RF_DW-1:0] rf_wdata_o,
  output logic             init_done_o
);

  localparam arb_state_e       ST_RST    = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [RF_AW-1:0] CNT_FIRST = 5'd1;
  localparam logic [RF_AW-1:0] CNT_LAST  = 5'd31;

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [RF_AW-1:0] cnt_r;
  logic [RF_AW-1:0] cnt_nxt_s;
  logic             run_s;
  logic [1:0]       gnt_s;
  logic             we_nxt_s;
  logic [RF_AW-1:0] waddr_nxt_s;
  logic [RF_DW-1:0] wdata_nxt_s;
  logic             we_r;
  logic [RF_AW-1:0] waddr_r;
  logic [RF_DW-1:0] wdata_r;
  logic             init_done_r;

  assign run_s = (state_r == ST_RUN);

  rr_arb2 #(
    .FIRST_PRIO(FIRST_PRIO)
  ) u_rr_arb2 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (run_s),
    .req_i ({req1_valid_i, req0_valid_i}),
    .gnt_o (gnt_s)
  );

  // Next state, clear counter and the write staged for the output register.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    we_nxt_s    = 1'b0;
    waddr_nxt_s = '0;
    wdata_nxt_s = '0;
    case (state_r)
      ST_CLEAR: begin
        we_nxt_s    = 1'b1;
        waddr_nxt_s = cnt_r;
        wdata_nxt_s = '0;
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r + 5'd1;
        end
      end
      ST_RUN: begin
        // x0 is hardwired: the handshake completes but nothing is written.
        if (gnt_s[0]) begin
          we_nxt_s    = (req0_addr_i != 5'd0);
          waddr_nxt_s = req0_addr_i;
          wdata_nxt_s = req0_data_i;
        end else if (gnt_s[1]) begin
          we_nxt_s    = (req1_addr_i != 5'd0);
          waddr_nxt_s = req1_addr_i;
          wdata_nxt_s = req1_data_i;
        end else begin
          we_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_RST;
        cnt_nxt_s   = CNT_FIRST;
      end
    endcase
  end

  // State, counter and registered write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_RST;
      cnt_r       <= CNT_FIRST;
      we_r        <= 1'b0;
      waddr_r     <= '0;
      wdata_r     <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      we_r        <= we_nxt_s;
      waddr_r     <= waddr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  assign req0_ready_o = gnt_s[0];
  assign req1_ready_o = gnt_s[1];
  assign rf_we_o      = we_r;
  assign rf_waddr_o   = waddr_r;
  assign rf_wdata_o   = wdata_r;
  assign init_done_o  = init_done_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter: a driver predicts grants and
// queues expected RF writes, a monitor checks the write port every cycle.
module tb_rf_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [4:0]  req0_addr_i = 5'd0, req1_addr_i = 5'd0;
  logic [31:0] req0_data_i = 32'd0, req1_data_i = 32'd0;
  logic        req0_ready_o, req1_ready_o, rf_we_o, init_done_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  rf_write_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   base = 0;
  int   prio = 0;
  int   checks = 0;
  int   errors = 0;
  bit   hold0 = 1'b0, hold1 = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit running();
    return (rst_ni === 1'b1) && ((cyc - base) >= 31);
  endfunction

  // Monitor: the RF port either shows the write due this cycle or nothing.
  always @(negedge clk_i) begin
    if (rst_ni !== 1'b1) begin
      chk("rst_we", 32'(rf_we_o), 32'd0);
      chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
      chk("rst_wdata", rf_wdata_o, 32'd0);
      chk("rst_init_done", 32'(init_done_o), 32'd0);
    end else begin
      chk("init_done", 32'(init_done_o), 32'(running()));
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("we", 32'(rf_we_o), 32'd1);
        chk("waddr", 32'(rf_waddr_o), 32'(e.a));
        chk("wdata", rf_wdata_o, e.d);
      end else begin
        chk("we_idle", 32'(rf_we_o), 32'd0);
      end
    end
  end

  task automatic release_reset();
    rst_ni = 1'b1;
    base   = cyc;
    prio   = 0;
    hold0  = 1'b0;
    hold1  = 1'b0;
    for (int k = 1; k <= 31; k++) q.push_back('{base + k, 5'(k), 32'd0});
  endtask

  task automatic assert_reset();
    rst_ni = 1'b0;
    q.delete();
    #1;
    chk("async_we", 32'(rf_we_o), 32'd0);
    chk("async_waddr", 32'(rf_waddr_o), 32'd0);
    chk("async_wdata", rf_wdata_o, 32'd0);
    chk("async_ready0", 32'(req0_ready_o), 32'd0);
    chk("async_ready1", 32'(req1_ready_o), 32'd0);
    chk("async_init_done", 32'(init_done_o), 32'd0);
  endtask

  // One cycle: called at posedge+1, drives, predicts and checks grants at negedge.
  task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      output bit acc0, output bit acc1);
    bit e0, e1;
    req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
    req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
    @(negedge clk_i);
    e0 = 1'b0; e1 = 1'b0;
    if (running()) begin
      if (v0 && v1) begin
        if (prio == 0) e0 = 1'b1; else e1 = 1'b1;
      end else if (v0) begin
        e0 = 1'b1;
      end else if (v1) begin
        e1 = 1'b1;
      end
    end
    chk("ready0", 32'(req0_ready_o), 32'(e0));
    chk("ready1", 32'(req1_ready_o), 32'(e1));
    if (e0) begin
      if (a0 != 5'd0) q.push_back('{cyc + 1, a0, d0});
      prio = 1;
    end
    if (e1) begin
      if (a1 != 5'd0) q.push_back('{cyc + 1, a1, d1});
      prio = 0;
    end
    acc0 = e0; acc1 = e1;
    @(posedge clk_i);
    #1;
  endtask

  // Random traffic; a stalled requester keeps its request unchanged.
  task automatic rand_cycles(input int n);
    bit a0c, a1c;
    for (int i = 0; i < n; i++) begin
      if (!hold0) begin
        req0_valid_i = ($urandom_range(0, 3) != 0);
        req0_addr_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        req0_data_i  = $urandom;
      end
      if (!hold1) begin
        req1_valid_i = ($urandom_range(0, 3) != 0);
        req1_addr_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        req1_data_i  = $urandom;
      end
      step(req0_valid_i, req0_addr_i, req0_data_i,
           req1_valid_i, req1_addr_i, req1_data_i, a0c, a1c);
      hold0 = req0_valid_i && !a0c;
      hold1 = req1_valid_i && !a1c;
    end
  endtask

  initial begin
    bit g0, g1;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    release_reset();
    rand_cycles(31);

    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, g0, g1);
    chk("dir_req0_only", 32'(g0), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, g0, g1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, g0, g1);
      chk("dir_alternate", 32'(g1), 32'(i % 2));
    end
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, g0, g1);
    chk("dir_addr0_ready", 32'(g1), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);
    step(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, g0, g1);
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h1010, g0, g1);
    chk("dir_stall_req0", 32'(g0), 32'd0);
    step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, g0, g1);
    chk("dir_stalled_accept", 32'(g0), 32'd1);

    rand_cycles(300);

    // Reset lands while a write is being accepted: it must be dropped.
    req0_valid_i = 1'b1; req0_addr_i = 5'd12; req0_data_i = 32'hCAFE;
    #2;
    assert_reset();
    repeat (2) @(posedge clk_i);
    #1;
    release_reset();
    rand_cycles(10);
    assert_reset();
    repeat (2) @(posedge clk_i);
    #1;
    release_reset();
    rand_cycles(31 + 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
